// File: rtl/seg_scan_master.sv
// seg_scan_master
// Scan controller for the 7-segment/keypad decoder. Each frame shifts
// {column select, screen select, digit} out over SCK/MOSI/EN, waits for
// the decoder to latch it, then samples the key column on MISO. Four
// frames make a scan, and a complete scan updates the key vector.
//
// Build option: define SEG_SCAN_DEBOUNCE_EN to make key_state follow raw
// scans only after DEBOUNCE identical scans in a row. Without it, every
// completed scan is copied to key_state directly.
//
// Handshake note: this block has no valid/ready interface. The decoder
// shifts on SCK rising edges while EN is high and latches on EN falling.
// The host writes digits with a single-cycle digit_we strobe that is
// always accepted.

module seg_scan_master #(
    parameter int CLK_DIV  = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       digit_we,
    input  logic [1:0] digit_addr,
    input  logic [3:0] digit_data,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       en,
    output logic [3:0] key_state,
    output logic       key_chg,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Phase counter covers the longest timed state (GAP, 2*CLK_DIV-1 cycles).
    localparam int DIVW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [DIVW-1:0] SH_LAST  = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] GAP_LAST = DIVW'(2 * CLK_DIV - 2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_GAP      = 3'd4,
        ST_SAMPLE   = 3'd5
    } state_t;

    // Empty marker block that only elaborates for an out-of-range
    // parameter set (both parameters must be at least 1).
    if (CLK_DIV < 1 || DEBOUNCE < 1) begin : g_param_out_of_range
    end

    state_t          r_state;
    state_t          w_next;
    logic [DIVW-1:0] r_div;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [1:0]      r_frame;
    logic [3:0]      r_digit [4];
    logic [3:0]      r_raw;
    logic [3:0]      r_key_state;
    logic            r_key_chg;

    logic            w_div_sh_last;
    logic            w_div_gap_last;
    logic            w_enter_load;
    logic            w_bit_adv;
    logic [1:0]      w_load_frame;
    logic [7:0]      w_load_word;
    logic [3:0]      w_raw_new;
    logic            w_scan_done;
    logic            w_key_update;

    assign w_div_sh_last  = (r_div == SH_LAST);
    assign w_div_gap_last = (r_div == GAP_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: LOAD, 8 x (SHIFT_LO, SHIFT_HI), GAP, SAMPLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (scan_en) w_next = ST_LOAD;
            ST_LOAD:     w_next = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_div_sh_last) w_next = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (w_div_sh_last) begin
                    w_next = (r_bit == 3'd7) ? ST_GAP : ST_SHIFT_LO;
                end
            end
            ST_GAP:      if (w_div_gap_last) w_next = ST_SAMPLE;
            ST_SAMPLE:   w_next = scan_en ? ST_LOAD : ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Output decode: serial lines follow the state directly, so a reset
    // drops them as soon as the state register clears.
    always_comb begin
        sck  = (r_state == ST_SHIFT_HI);
        en   = (r_state == ST_LOAD) || (r_state == ST_SHIFT_LO) ||
               (r_state == ST_SHIFT_HI);
        mosi = en & r_shift[7];
        busy = (r_state != ST_IDLE);
    end

    assign dbg_state = r_state;
    assign key_state = r_key_state;
    assign key_chg   = r_key_chg;

    // Phase counter restarts on every state change and rests at 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_state != w_next || r_state == ST_IDLE) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // The word is captured on the edge that enters LOAD, so its MSB is
    // already on mosi during the LOAD cycle. Coming from SAMPLE the frame
    // index advances on that same edge, hence the look-ahead index.
    assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);
    assign w_bit_adv    = (r_state == ST_SHIFT_HI) && (w_next == ST_SHIFT_LO);
    assign w_load_frame = (r_state == ST_SAMPLE) ? (r_frame + 2'd1) : r_frame;
    assign w_load_word  = {w_load_frame, w_load_frame, r_digit[w_load_frame]};

    // Shift register and bit counter: new bit goes out as sck falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_bit   <= '0;
        end else if (w_enter_load) begin
            r_shift <= w_load_word;
            r_bit   <= '0;
        end else if (w_bit_adv) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit + 3'd1;
        end
    end

    // Frame index advances after each SAMPLE and wraps 3 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_frame <= r_frame + 2'd1;
        end
    end

    // Digit registers accept host writes at any time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= '0;
            end
        end else if (digit_we) begin
            r_digit[digit_addr] <= digit_data;
        end
    end

    // Raw key vector with the column of the current frame replaced.
    always_comb begin
        w_raw_new          = r_raw;
        w_raw_new[r_frame] = ~miso;
    end

    assign w_scan_done = (r_state == ST_SAMPLE) && (r_frame == 2'd3);

    // Raw key capture: MISO is low when the selected column is pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_raw <= w_raw_new;
        end
    end

`ifdef SEG_SCAN_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE);

    logic [3:0]     r_prev_raw;
    logic [DBW-1:0] r_db_cnt;
    logic [DBW-1:0] w_db_cnt_nxt;

    // Run-length of identical scans, saturating at DEBOUNCE.
    always_comb begin
        w_db_cnt_nxt = DBW'(1);
        if (w_raw_new == r_prev_raw) begin
            w_db_cnt_nxt = (r_db_cnt == DB_MAX) ? r_db_cnt : (r_db_cnt + 1'b1);
        end
    end

    // Debounce history, updated once per complete scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_raw <= '0;
            r_db_cnt   <= '0;
        end else if (w_scan_done) begin
            r_prev_raw <= w_raw_new;
            r_db_cnt   <= w_db_cnt_nxt;
        end
    end

    assign w_key_update = w_scan_done && (w_db_cnt_nxt == DB_MAX) &&
                          (w_raw_new != r_key_state);
`else
    assign w_key_update = w_scan_done && (w_raw_new != r_key_state);
`endif

    // Key vector and its one-cycle change pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_state <= '0;
            r_key_chg   <= 1'b0;
        end else begin
            r_key_chg <= 1'b0;
            if (w_key_update) begin
                r_key_state <= w_raw_new;
                r_key_chg   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_master.sv
// Bench for seg_scan_master (CLK_DIV=2, DEBOUNCE=3) with a decoder model:
// it shifts MOSI on SCK rise, latches the column select when EN falls and
// drives MISO low when the latched column's key is pressed.

module tb_seg_scan_master;

  localparam int C           = 2;
  localparam int DB          = 3;
  localparam int EN_LEN      = 1 + 16 * C;
  localparam int FRAME_LEN   = 1 + 18 * C;
  localparam int FRAME_BOUND = 2 * FRAME_LEN + 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic       digit_we;
  logic [1:0] digit_addr;
  logic [3:0] digit_data;
  logic       miso;
  logic       sck;
  logic       mosi;
  logic       en;
  logic [3:0] key_state;
  logic       key_chg;
  logic       busy;
  logic [2:0] dbg_state;

  seg_scan_master #(.CLK_DIV(C), .DEBOUNCE(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .digit_we   (digit_we),
    .digit_addr (digit_addr),
    .digit_data (digit_data),
    .miso       (miso),
    .sck        (sck),
    .mosi       (mosi),
    .en         (en),
    .key_state  (key_state),
    .key_chg    (key_chg),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [3:0] tb_digits [4];
  logic [1:0] tb_frame;
  logic [3:0] pressed = 4'b0000;

  // decoder model
  logic [7:0] dec_sr  = 8'h00;
  logic [1:0] dec_sel = 2'd0;
  assign miso = ~pressed[dec_sel];

  logic mon_prev_en  = 1'b0;
  logic mon_prev_sck = 1'b0;
  int   mon_bits     = 0;
  int   mon_en_len   = 0;
  int   frames_done  = 0;
  int   chg_cnt      = 0;
  int   cyc          = 0;
  int   mon_last_rise = 0;
  int   mon_period   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: compares each complete frame with the queue head
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (rst) begin
      mon_bits     = 0;
      mon_en_len   = 0;
      mon_prev_en  = 1'b0;
      mon_prev_sck = 1'b0;
    end else begin
      if (key_chg) chg_cnt++;
      if (en && !mon_prev_en) begin
        mon_period    = cyc - mon_last_rise;
        mon_last_rise = cyc;
      end
      if (sck && !mon_prev_sck) begin
        dec_sr = {dec_sr[6:0], mosi};
        mon_bits++;
      end
      if (en) mon_en_len++;
      if (!en && mon_prev_en) begin
        dec_sel = dec_sr[7:6];
        if (mon_bits == 8) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'h0, dec_sr}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'h0, dec_sr}, {24'h0, e});
          end
          check("en_high_cycles", mon_en_len, EN_LEN);
          frames_done++;
        end
        mon_bits   = 0;
        mon_en_len = 0;
      end
      mon_prev_en  = en;
      mon_prev_sck = sck;
    end
  end

  // driver tasks
  task automatic wait_sck();
    int n = 0;
    while (sck !== 1'b1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (sck !== 1'b1) check("sck_wait_timeout", 0, 1);
  endtask

  task automatic wait_frame_end();
    int start = frames_done;
    int n = 0;
    while (frames_done == start && n < FRAME_BOUND) begin
      @(negedge clk); #1;
      n++;
    end
    if (frames_done == start) check("frame_end_timeout", 0, 1);
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [3:0] d);
    digit_addr = a;
    digit_data = d;
    digit_we   = 1'b1;
    @(negedge clk); #1;
    digit_we   = 1'b0;
    tb_digits[a] = d;
  endtask

  // One frame: expected word pushed from the bench's own digit/frame model.
  task automatic do_frame(input logic wr, input logic [1:0] a, input logic [3:0] d,
                          input logic drop);
    exp_q.push_back({tb_frame, tb_frame, tb_digits[tb_frame]});
    if (wr || drop) begin
      wait_sck();
      if (drop) begin
        check("busy_mid_frame", {31'h0, busy}, 1);
        scan_en = 1'b0;
      end
      if (wr) write_digit(a, d);
    end
    wait_frame_end();
    tb_frame = tb_frame + 2'd1;
  endtask

  // Four frames, then step past frame 3's SAMPLE and the key_chg cycle.
  task automatic do_scan();
    for (int f = 0; f < 4; f++) do_frame(1'b0, 2'd0, 4'd0, 1'b0);
    repeat (2 * C + 1) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] press;
    logic [3:0] exp_state;
    logic       exp_chg;
  } scan_vec_t;

  scan_vec_t tbl [11];

  initial begin
    int chg0;

`ifdef SEG_SCAN_DEBOUNCE_EN
    tbl[0]  = '{4'b0100, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0100, 1'b0};
    tbl[5]  = '{4'b0000, 4'b0100, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0};
`else
    tbl[0]  = '{4'b0100, 4'b0100, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0010, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0};
`endif

    rst        = 1'b1;
    scan_en    = 1'b0;
    digit_we   = 1'b0;
    digit_addr = 2'd0;
    digit_data = 4'd0;
    tb_frame   = 2'd0;
    for (int i = 0; i < 4; i++) tb_digits[i] = 4'd0;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_sck", {31'h0, sck}, 0);
    check("rst_mosi", {31'h0, mosi}, 0);
    check("rst_en", {31'h0, en}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_key_state", {28'h0, key_state}, 0);
    check("rst_key_chg", {31'h0, key_chg}, 0);

    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("idle_en", {31'h0, en}, 0);
    check("idle_busy", {31'h0, busy}, 0);

    // digits 1,2,3,4 -> frames 0x01, 0x52, 0xA3, 0xF4
    write_digit(2'd0, 4'h1);
    write_digit(2'd1, 4'h2);
    write_digit(2'd2, 4'h3);
    write_digit(2'd3, 4'h4);
    scan_en = 1'b1;
    do_scan();
    check("frame_period", mon_period, FRAME_LEN);

    // key press / release / glitch table, one row per full scan
    for (int i = 0; i < 11; i++) begin
      pressed = tbl[i].press;
      chg0    = chg_cnt;
      do_scan();
      check($sformatf("key_state_scan%0d", i), {28'h0, key_state}, {28'h0, tbl[i].exp_state});
      check($sformatf("key_chg_scan%0d", i), chg_cnt - chg0, {31'h0, tbl[i].exp_chg});
    end

    // digit write during frame 0 shifting: current frame keeps the old value
    do_frame(1'b1, 2'd0, 4'hA, 1'b0);
    for (int f = 0; f < 4; f++) do_frame(1'b0, 2'd0, 4'd0, 1'b0);

    // scan_en drop in frame 1: frame finishes, then IDLE
    do_frame(1'b0, 2'd0, 4'd0, 1'b1);
    repeat (2 * C + 1) @(negedge clk);
    #1;
    check("stop_en", {31'h0, en}, 0);
    check("stop_busy", {31'h0, busy}, 0);
    repeat (10) @(negedge clk);
    #1;
    check("stop_stays_idle", {31'h0, busy}, 0);
    scan_en = 1'b1;
    do_frame(1'b0, 2'd0, 4'd0, 1'b0);

    // asynchronous reset in the middle of a frame
    wait_sck();
    rst = 1'b1;
    #1;
    check("async_rst_sck", {31'h0, sck}, 0);
    check("async_rst_mosi", {31'h0, mosi}, 0);
    check("async_rst_en", {31'h0, en}, 0);
    check("async_rst_busy", {31'h0, busy}, 0);
    check("async_rst_key_state", {28'h0, key_state}, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    tb_frame = 2'd0;
    for (int i = 0; i < 4; i++) tb_digits[i] = 4'd0;
    do_frame(1'b0, 2'd0, 4'd0, 1'b0);
    scan_en = 1'b0;
    repeat (2 * FRAME_LEN) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
